// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
//   Operand side : in_valid, in_ready, a, b, op
//   Result side  : out_valid, out_ready, result, zero, carry, negative, overflow
//   master modport: the producer/consumer around the ALU (decode stage / writeback).
//   slave  modport: the ALU itself.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, carry, negative, overflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, carry, negative, overflow
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on operands and results.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : alu_pipe_if.slave (in_valid/in_ready/a/b/op in,
//            out_valid/out_ready/result/zero/carry/negative/overflow out)
// Opcodes: 000 add, 001 mul (or add), 010 sub, 011 xor, 100 and, 101 or,
//          110 shl, 111 shr (logical); shift amount is b[SHW-1:0].
// Build option: define ALU_MUL_EN to make op 001 an iterative unsigned
//   shift-add multiply (result valid WIDTH+1 cycles after accept); without it
//   op 001 is a single-cycle add.
module alu_pipe #(
  parameter int  WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, FULL, MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, FULL} state_t;
`endif

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_neg;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_complete;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;
  assign bus.negative  = r_neg;
  assign bus.overflow  = r_ovf;

`ifdef ALU_MUL_EN
  assign w_in_ready = (r_state != MUL) && (!r_out_valid || bus.out_ready);
`else
  assign w_in_ready = !r_out_valid || bus.out_ready;
`endif
  assign bus.in_ready = w_in_ready;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_complete   = r_out_valid && bus.out_ready;

  // Single-cycle datapath. The extra top bit of the add/sub/shl results is the
  // carry/borrow/shifted-out bit; for shr an extra bottom bit catches the last
  // bit shifted out. A zero shift amount leaves those extra bits at 0.
  always_comb begin
    w_shamt = bus.b[SHW-1:0];
    w_add   = {1'b0, bus.a} + {1'b0, bus.b};
    w_sub   = {1'b0, bus.a} - {1'b0, bus.b};
    w_shl   = {1'b0, bus.a} << w_shamt;
    w_shr   = {bus.a, 1'b0} >> w_shamt;
    w_res   = w_add[WIDTH-1:0];
    w_c     = w_add[WIDTH];
    w_v     = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_add[WIDTH-1] != bus.a[WIDTH-1]);
    case (bus.op)
      3'b010: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_sub[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b011: begin
        w_res = bus.a ^ bus.b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      3'b100: begin
        w_res = bus.a & bus.b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      3'b101: begin
        w_res = bus.a | bus.b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      3'b110: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
        w_v   = 1'b0;
      end
      3'b111: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
        w_v   = 1'b0;
      end
      default: ; // add (000, and 001 when the multiplier is not built)
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW:0]       r_cnt;
  logic               w_is_mul;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_is_mul = (bus.op == 3'b001);

  // Right-shifting multiplier: the low half starts as the multiplier and is
  // consumed LSB-first while partial sums accumulate in the high half.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef ALU_MUL_EN
      r_mcand     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
`endif
    end else begin
`ifdef ALU_MUL_EN
      // WIDTH step cycles, then one cycle to publish the product.
      if (r_state == MUL) begin
        if (r_cnt == CNT_LAST) begin
          r_result    <= r_acc[WIDTH-1:0];
          r_zero      <= (r_acc[WIDTH-1:0] == '0);
          r_carry     <= |r_acc[2*WIDTH-1:WIDTH];
          r_neg       <= r_acc[WIDTH-1];
          r_ovf       <= 1'b0;
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
          r_state     <= FULL;
        end else begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (w_accept && w_is_mul) begin
        r_mcand     <= bus.a;
        r_acc       <= {{WIDTH{1'b0}}, bus.b};
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
        r_state     <= MUL;
      end else
`endif
      if (w_accept) begin
        r_result    <= w_res;
        r_zero      <= (w_res == '0);
        r_carry     <= w_c;
        r_neg       <= w_res[WIDTH-1];
        r_ovf       <= w_v;
        r_out_valid <= 1'b1;
        r_state     <= FULL;
      end else if (w_complete) begin
        r_out_valid <= 1'b0;
        r_state     <= IDLE;
      end
    end
  end

endmodule
